sram_core_mb: RTL and testbench
===============================

Name: sram_core_mb

Overview:
- Parametrised successor of the two-bank byte-lane SRAM core.
- Address space is split across NBANKS banks. Each bank is DATA_W/8 byte-wide single-port macros sharing a per-bank address.
- Adds a registered read path with valid, and a built-in March C- BIST controller that tests all banks and lanes in parallel. This replaces the per-macro BIST instances.
- Sits behind the AHB SRAM controller; the controller sees a simple request/write/byte-strobe interface.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8; lanes L = DATA_W/8.
- BANK_AW, 13, address bits per bank; depth D = 2**BANK_AW.
- NBANKS, 2, bank count; power of 2, >=1; BSEL_W = max(1, clog2(NBANKS)).
- ADDR_W, BANK_AW+clog2(NBANKS), total word address width (derived; do not override).

Ports:
- sram_clk  in  1  clock; all logic rising-edge.
- sram_reset  in  1  asynchronous, active-high reset.
- sram_req  in  1  functional access valid this cycle.
- sram_wen  in  1  0 = write, 1 = read.
- sram_ByteEna  in  L  active-low byte strobes (writes only; reads return full word).
- sram_Addr  in  ADDR_W  word address; the top clog2(NBANKS) bits select the bank.
- sram_Wdata  in  DATA_W  write data.
- sram_Rdata  out  DATA_W  read data.
- sram_rvalid  out  1  sram_Rdata valid, one-cycle pulse.
- sram_busy  out  1  BIST owns the arrays; functional requests are dropped.
- bist_ten  in  1  BIST enable, level.
- bist_done  out  1  BIST completed.
- bist_fail  out  1  BIST miscompare, sticky for the run.

Behaviour:
Reset:
- Reset values: sram_Rdata=0, sram_rvalid=0, sram_busy=0, bist_done=0, bist_fail=0, FSM=IDLE. No macro is selected during reset.
- Array contents are not reset.

Functional path (FSM=IDLE and bist_ten=0):
- Only the addressed bank gets csn=sram_ByteEna; all other banks get all-ones csn.
- Write: the lane is written at the clock edge where sram_req=1, sram_wen=0 and its strobe is 0. No rvalid is produced.
- Read: request in cycle N gives sram_rvalid=1 in cycle N+1 with the full word from the bank captured in a bank-select register at cycle N. It never uses the current address, so back-to-back reads to different banks return correct data.
- Write then read of the same address in the next cycle returns the new data.
- Reads with strobes all 1 still return data (strobes are ignored for reads).
- sram_req=0: no macro is selected and sram_rvalid=0 next cycle.

BIST FSM:
- States: IDLE, W0_UP, RW01_UP, RW10_UP, RW01_DN, RW10_DN, R0_DN, DONE.
- IDLE->W0_UP when bist_ten is sampled 1. bist_done and bist_fail clear on this transition.
- Every state other than IDLE asserts sram_busy. All banks and all lanes are enabled with a common bank address.
- W0_UP: writes 0, address 0..D-1, 1 cycle per address.
- RWxy states: 2 cycles per address.
  - Cycle 1 reads.
  - Cycle 2 compares all NBANKS*DATA_W bits against x-pattern (all-0 or all-1) and writes y-pattern.
  - _UP states go ascending; _DN states go descending from D-1.
- R0_DN: reads descending, 1 cycle per address. Each compare is pipelined one cycle behind its read; the final compare occurs in the cycle after the last read.
- Any miscompare sets bist_fail, which holds until the next start or reset.
- DONE is entered after the final compare. bist_done=1 exactly 10*D+2 cycles after the cycle bist_ten was first sampled 1.
- DONE holds bist_done and bist_fail while bist_ten=1. DONE->IDLE when bist_ten=0, which clears bist_done and keeps bist_fail.
- bist_ten=0 in any run state aborts to IDLE next cycle: bist_done=0, bist_fail=0, busy drops.
- The address counter is BANK_AW bits. Wrap at D-1 (ascending) or 0 (descending) advances the state; the counter must never wrap silently.
- Functional requests during busy are ignored: no write, no rvalid. The controller must gate on sram_busy.
- Asserting sram_reset mid-run forces IDLE immediately.

Decomposition:
- Package sram_core_pkg: BIST state enum, march pattern constants (all-0, all-1), helper clog2 function.
- Sub-module sram_lane_macro: one byte-wide, depth-D, single-port macro with active-low cen/wen and 1-cycle registered read. Instantiated NBANKS*L times via generate.
- The top level holds the decode, read mux/pipeline and BIST FSM.

Test Plan:
1. Defaults, reset: write 0xDEADBEEF @0x0000 and 0xCAFEF00D @0x2000 with strobes 0000, then read both back-to-back -> rvalid on consecutive cycles, data 0xDEADBEEF then 0xCAFEF00D.
2. Byte strobes: write 0x11223344 @0x10 with strobes 0000, then 0xAABBCCDD with strobes 1010 -> read returns 0x11BB33DD.
3. BIST clean, BANK_AW=4, NBANKS=4: raise bist_ten -> sram_busy=1 immediately after; bist_done=1 after 162 cycles, bist_fail=0; lower ten -> done=0, busy=0.
4. BIST fault: force bank 2 lane 1 bit 3 stuck-at-1 -> bist_fail=1 at the first R0 compare of RW01_UP, bist_done=1 at cycle 162, fail stays 1.
5. Abort/busy: ten high for 20 cycles, then low -> IDLE, done=0, fail=0. A read issued while busy -> no rvalid. A read 1 cycle after busy drops -> rvalid next cycle.
6. Reset mid-run: assert sram_reset during RW10_DN -> all outputs 0 asynchronously, FSM IDLE; a subsequent write/read of 0x5A5A5A5A round-trips.

Source files
------------

// File: rtl/sram_core_pkg.sv
// Shared types and constants for the multi-bank byte-lane SRAM core and its
// March C- BIST sequencer.
package sram_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W0_UP   = 3'd1,
    ST_RW01_UP = 3'd2,
    ST_RW10_UP = 3'd3,
    ST_RW01_DN = 3'd4,
    ST_RW10_DN = 3'd5,
    ST_R0_DN   = 3'd6,
    ST_DONE    = 3'd7
  } bist_state_e;

  // March background bits; replicated across the full word at the point of use.
  localparam logic PAT_ZERO = 1'b0;
  localparam logic PAT_ONE  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sram_lane_macro.sv
// One byte-wide single-port SRAM macro: active-low chip enable and write
// enable, read data registered one cycle after the access. Contents are not reset.
module sram_lane_macro #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    d,
  output logic [7:0]    q
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) mem[addr] <= d;
      else      q         <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_core_mb.sv
// Banked byte-lane SRAM core: address/strobe decode, registered read return
// with valid, and a March C- BIST that exercises every bank and lane in parallel.
module sram_core_mb
  import sram_core_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int BANK_AW = 13,
  parameter int NBANKS  = 2,
  parameter int ADDR_W  = BANK_AW + clog2(NBANKS)
) (
  input  logic                sram_clk,
  input  logic                sram_reset,
  input  logic                sram_req,
  input  logic                sram_wen,
  input  logic [DATA_W/8-1:0] sram_ByteEna,
  input  logic [ADDR_W-1:0]   sram_Addr,
  input  logic [DATA_W-1:0]   sram_Wdata,
  output logic [DATA_W-1:0]   sram_Rdata,
  output logic                sram_rvalid,
  output logic                sram_busy,
  input  logic                bist_ten,
  output logic                bist_done,
  output logic                bist_fail,
  output bist_state_e         bist_state
);

  localparam int L      = DATA_W / 8;
  localparam int BSEL_W = (clog2(NBANKS) > 0) ? clog2(NBANKS) : 1;
  localparam logic [BANK_AW-1:0] ADDR_MAX = '1;

  // Request interface: sram_req is sampled on every rising edge with no
  // backpressure. A read accepted in cycle N returns sram_Rdata with a
  // one-cycle sram_rvalid pulse in cycle N+1; writes return nothing. Requests
  // made while sram_busy is high (or while bist_ten is high) are dropped.

  bist_state_e state_q, state_d;
  logic [BANK_AW-1:0] addr_q, addr_d;
  logic phase_q, phase_d;
  logic fail_q, fail_d;
  logic cmp_q, cmp_d;

  logic busy;
  logic bist_cen, bist_wen, bist_dbit, bist_exp, bist_cmp;

  logic [BSEL_W-1:0] bank_sel, rd_bank_q;
  logic rd_pend_q;
  logic func_en, func_rd;

  logic [BANK_AW-1:0] mac_addr;
  logic               mac_wen;
  logic [DATA_W-1:0]  mac_d;
  logic [NBANKS-1:0][DATA_W-1:0] bank_q;

  generate
    if (NBANKS > 1) begin : g_bsel
      assign bank_sel = sram_Addr[ADDR_W-1:BANK_AW];
    end else begin : g_bsel_one
      assign bank_sel = '0;
    end
  endgenerate

  assign busy    = (state_q != ST_IDLE);
  assign func_en = !busy && !bist_ten && sram_req;
  assign func_rd = func_en && sram_wen;

  // During BIST every macro shares the march address and background data.
  assign mac_addr = busy ? addr_q : sram_Addr[BANK_AW-1:0];
  assign mac_wen  = busy ? bist_wen : sram_wen;
  assign mac_d    = busy ? {DATA_W{bist_dbit}} : sram_Wdata;

  generate
    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic [L-1:0] csn;

      // Reads enable every lane of the addressed bank; strobes only gate writes.
      always_comb begin
        csn = '1;
        if (busy) begin
          csn = {L{bist_cen}};
        end else if (func_en && (bank_sel == BSEL_W'(b))) begin
          csn = sram_wen ? '0 : sram_ByteEna;
        end
      end

      for (genvar l = 0; l < L; l++) begin : g_lane
        logic [7:0] q;

        sram_lane_macro #(.AW(BANK_AW)) u_mac (
          .clk  (sram_clk),
          .cen  (csn[l]),
          .wen  (mac_wen),
          .addr (mac_addr),
          .d    (mac_d[l*8 +: 8]),
          .q    (q)
        );

        assign bank_q[b][l*8 +: 8] = q;
      end
    end
  endgenerate

  always_ff @(posedge sram_clk or posedge sram_reset) begin
    if (sram_reset) begin
      rd_pend_q <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      rd_pend_q <= func_rd;
      if (func_rd) rd_bank_q <= bank_sel;
    end
  end

  // Steering uses the bank captured with the request, never the live address.
  assign sram_rvalid = rd_pend_q;
  assign sram_Rdata  = rd_pend_q ? bank_q[rd_bank_q] : '0;

  always_ff @(posedge sram_clk or posedge sram_reset) begin
    if (sram_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
      fail_q  <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      fail_q  <= fail_d;
      cmp_q   <= cmp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    fail_d    = fail_q;
    cmp_d     = 1'b0;
    bist_cen  = 1'b1;
    bist_wen  = 1'b1;
    bist_dbit = PAT_ZERO;
    bist_exp  = PAT_ZERO;
    bist_cmp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bist_ten) begin
          state_d = ST_W0_UP;
          addr_d  = '0;
          phase_d = 1'b0;
          fail_d  = 1'b0;
        end
      end

      ST_W0_UP: begin
        bist_cen = 1'b0;
        bist_wen = 1'b0;
        if (addr_q == ADDR_MAX) begin
          state_d = ST_RW01_UP;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      // phase 0 reads the cell, phase 1 checks it and writes the inverse.
      ST_RW01_UP, ST_RW10_UP, ST_RW01_DN, ST_RW10_DN: begin
        bist_cen  = 1'b0;
        bist_exp  = (state_q == ST_RW10_UP || state_q == ST_RW10_DN) ? PAT_ONE : PAT_ZERO;
        bist_dbit = ~bist_exp;
        phase_d   = ~phase_q;
        if (phase_q) begin
          bist_wen = 1'b0;
          bist_cmp = 1'b1;
          case (state_q)
            ST_RW01_UP: begin
              if (addr_q == ADDR_MAX) begin
                state_d = ST_RW10_UP;
                addr_d  = '0;
              end else addr_d = addr_q + 1'b1;
            end
            ST_RW10_UP: begin
              if (addr_q == ADDR_MAX) begin
                state_d = ST_RW01_DN;
                addr_d  = ADDR_MAX;
              end else addr_d = addr_q + 1'b1;
            end
            ST_RW01_DN: begin
              if (addr_q == '0) begin
                state_d = ST_RW10_DN;
                addr_d  = ADDR_MAX;
              end else addr_d = addr_q - 1'b1;
            end
            default: begin
              if (addr_q == '0) begin
                state_d = ST_R0_DN;
                addr_d  = ADDR_MAX;
              end else addr_d = addr_q - 1'b1;
            end
          endcase
        end
      end

      // Reads stream one per cycle; cmp_q checks the previous read, and the
      // phase bit buys one extra cycle for the compare of address 0.
      ST_R0_DN: begin
        bist_cmp = cmp_q;
        if (!phase_q) begin
          bist_cen = 1'b0;
          cmp_d    = 1'b1;
          if (addr_q == '0) phase_d = 1'b1;
          else              addr_d  = addr_q - 1'b1;
        end else begin
          state_d = ST_DONE;
          phase_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (!bist_ten) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (bist_cmp && (bank_q != {(NBANKS*DATA_W){bist_exp}})) fail_d = 1'b1;

    if (busy && (state_q != ST_DONE) && !bist_ten) begin
      state_d = ST_IDLE;
      phase_d = 1'b0;
      cmp_d   = 1'b0;
      fail_d  = 1'b0;
    end
  end

  assign sram_busy  = busy;
  assign bist_done  = (state_q == ST_DONE);
  assign bist_fail  = fail_q;
  assign bist_state = state_q;

endmodule

// File: tb/tb_sram_core_mb.sv
// Directed bench for sram_core_mb with 4 banks of depth 16: reads are checked
// by a scoreboard monitor, BIST status by direct checks against cycle counts.
module tb_sram_core_mb;
  import sram_core_pkg::*;

  localparam int DATA_W  = 32;
  localparam int BANK_AW = 4;
  localparam int NBANKS  = 4;
  localparam int ADDR_W  = 6;
  localparam int BIST_CYCLES = 10 * (2**BANK_AW) + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              wen;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              busy;
  logic              ten;
  logic              done;
  logic              fail;
  bist_state_e       st;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int n_done;
  int n_fail;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sram_core_mb #(
    .DATA_W  (DATA_W),
    .BANK_AW (BANK_AW),
    .NBANKS  (NBANKS)
  ) dut (
    .sram_clk     (clk),
    .sram_reset   (rst),
    .sram_req     (req),
    .sram_wen     (wen),
    .sram_ByteEna (be),
    .sram_Addr    (addr),
    .sram_Wdata   (wdata),
    .sram_Rdata   (rdata),
    .sram_rvalid  (rvalid),
    .sram_busy    (busy),
    .bist_ten     (ten),
    .bist_done    (done),
    .bist_fail    (fail),
    .bist_state   (st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic drv_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; wen = 1'b0; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; wen = 1'b1;
  endtask

  task automatic drv_read(input logic [ADDR_W-1:0] a, input logic [3:0] b, input logic [31:0] e);
    req = 1'b1; wen = 1'b1; addr = a; be = b;
    exp_q.push_back(e);
    @(negedge clk);
    req = 1'b0;
    check("rd_latency_rvalid", {31'd0, rvalid}, 32'd1);
  endtask

  task automatic drv_idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Raise bist_ten and count cycles until done; n=1 is the cycle after sampling.
  task automatic run_bist(output int n, output int first_fail);
    n = 0;
    first_fail = 0;
    ten = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (fail && first_fail == 0) first_fail = n;
    end while (!done && n < 400);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got rvalid with data %h, required no rvalid (t=%0t)", rdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", rdata, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = 1'b0; wen = 1'b1; be = '1; addr = '0; wdata = '0; ten = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdata",  rdata, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_fail",   {31'd0, fail}, 32'd0);
    check("rst_state",  32'(st), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Two banks, back-to-back reads
    drv_write(6'h00, 32'hDEADBEEF, 4'b0000);
    drv_write(6'h20, 32'hCAFEF00D, 4'b0000);
    drv_read (6'h00, 4'b0000, 32'hDEADBEEF);
    drv_read (6'h20, 4'b0000, 32'hCAFEF00D);
    drv_idle(2);

    // Byte strobes; read with all strobes high still returns the word
    drv_write(6'h10, 32'h11223344, 4'b0000);
    drv_write(6'h10, 32'hAABBCCDD, 4'b1010);
    drv_read (6'h10, 4'b1111, 32'h11BB33DD);
    drv_write(6'h35, 32'h01020304, 4'b0000);
    drv_read (6'h35, 4'b1111, 32'h01020304);
    drv_idle(3);

    // Clean BIST
    run_bist(n_done, n_fail);
    check("bist_done_cycle", n_done, BIST_CYCLES);
    check("bist_clean_fail", {31'd0, fail}, 32'd0);
    check("bist_clean_first_fail", n_fail, 0);
    repeat (3) @(negedge clk);
    check("bist_done_hold", {31'd0, done}, 32'd1);
    check("bist_busy_in_done", {31'd0, busy}, 32'd1);
    ten = 1'b0;
    @(negedge clk);
    check("bist_done_clear", {31'd0, done}, 32'd0);
    check("bist_busy_clear", {31'd0, busy}, 32'd0);
    check("bist_state_idle", 32'(st), 32'(ST_IDLE));

    // Fault on bank 2 lane 1: bit 3 reads high (other bits of that lane held low)
    force dut.g_bank[2].g_lane[1].q = 8'h08;
    run_bist(n_done, n_fail);
    check("fault_first_fail_cycle", n_fail, 19);
    check("fault_done_cycle", n_done, BIST_CYCLES);
    check("fault_fail_at_done", {31'd0, fail}, 32'd1);
    release dut.g_bank[2].g_lane[1].q;
    ten = 1'b0;
    @(negedge clk);
    check("fault_done_clear", {31'd0, done}, 32'd0);
    check("fault_fail_kept", {31'd0, fail}, 32'd1);

    // Abort after 20 cycles, with a read dropped while busy
    ten = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 10) begin
        req = 1'b1; wen = 1'b1; be = 4'b0000; addr = 6'h00;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      if (i == 2)  check("fail_cleared_on_start", {31'd0, fail}, 32'd0);
      if (i == 10) check("no_rvalid_while_busy", {31'd0, rvalid}, 32'd0);
    end
    ten = 1'b0;
    @(negedge clk);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_done",  {31'd0, done}, 32'd0);
    check("abort_fail",  {31'd0, fail}, 32'd0);
    check("abort_state", 32'(st), 32'(ST_IDLE));
    // Address 0 completed r0,w1 before the abort; bank 2 word 3 only saw w0.
    drv_read(6'h00, 4'b1111, 32'hFFFFFFFF);
    drv_read(6'h23, 4'b1111, 32'h00000000);
    drv_idle(3);

    // Reset in the middle of RW10_DN (cycles 113..144 of the run)
    ten = 1'b1;
    repeat (120) @(negedge clk);
    check("mid_state_rw10_dn", 32'(st), 32'(ST_RW10_DN));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy",   {31'd0, busy}, 32'd0);
    check("mid_rst_done",   {31'd0, done}, 32'd0);
    check("mid_rst_fail",   {31'd0, fail}, 32'd0);
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_rdata",  rdata, 32'd0);
    check("mid_rst_state",  32'(st), 32'(ST_IDLE));
    ten = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drv_write(6'h3F, 32'h5A5A5A5A, 4'b0000);
    drv_read (6'h3F, 4'b1111, 32'h5A5A5A5A);
    drv_idle(3);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
